seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
- Holds a double-buffered digit/decimal-point frame and cycles through the digits at a fixed per-digit slot time.
- Inserts a ghosting blank at the start of each slot and optionally suppresses leading zeros.
- Sits between any value producer (counters, frame-rate meters, debug registers) and the board display pins; the per-digit hex decode is done by instantiating Seg7_lut.

Parameters:
- NUM_DIG, 8: number of digits scanned (2..8).
- SCAN_DIV, 50000: iCLK cycles per digit slot (1 kHz per digit at 50 MHz); must be greater than BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all digit selects inactive.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  synchronous reset, active-high.
- iWR_EN  in  1  one-cycle write strobe into the shadow frame.
- iWR_DATA  in  4*NUM_DIG  hex nibbles; digit k is [4k+3:4k], digit 0 is rightmost.
- iWR_DP  in  NUM_DIG  decimal points, 1 = lit.
- iLZB  in  1  leading-zero blank enable; sampled live.
- oPEND  out  1  shadow frame written but not yet committed to the display frame.
- oFRAME  out  1  one-cycle pulse on every commit boundary, i.e. scan wrap to digit 0.
- oSEL  out  NUM_DIG  digit selects, active-low, one-hot-low when active.
- oSEG  out  8  {dp, g..a}, active-low; [6:0] comes from Seg7_lut.

Behaviour:
- Reset values: slot counter 0, digit index 0, shadow and display frames all 0, oPEND 0, oFRAME 0, oSEL all 1, oSEG 8'hFF.
- Reset asserted mid-scan takes effect on the next iCLK edge; no partial slot completes.

Slot counter:
- cnt counts 0..SCAN_DIV-1 and wraps.
- At cnt==SCAN_DIV-1, idx advances: idx = (idx==NUM_DIG-1) ? 0 : idx+1.

Commit:
- The commit boundary is the cycle where cnt==SCAN_DIV-1 and idx==NUM_DIG-1.
- At that cycle, display <= shadow, oPEND clears, and oFRAME pulses high in the following cycle (aligned with idx becoming 0).
- The display frame never changes at any other time, so there is no tearing.

Write:
- iWR_EN loads shadow <= {iWR_DATA, iWR_DP} and sets oPEND.
- Multiple writes before a boundary: the last one wins.
- Write on the commit-boundary cycle bypasses the shadow: the written data goes directly to display and to shadow, and oPEND ends at 0.

Leading-zero blanking (iLZB=1):
- Digit k (k>=1) is blanked when its nibble and the nibbles of all higher digits are 0 and none of those digits has its DP set.
- Digit 0 is never blanked.
- A blanked digit drives oSEG[6:0]=7'h7F and its own DP bit.

Output stage (registered, one-cycle latency from cnt/idx):
- If cnt < BLANK_CYC: oSEL all 1, oSEG 8'hFF.
- Else: oSEL[idx]=0 and others 1; oSEG = {~dp[idx], lut(display nibble idx)}, or 7'h7F in [6:0] when blanked.

Decomposition:
- Shared package seg7_pkg holds: default SCAN_DIV/BLANK_CYC, SEG_OFF=8'hFF, SEL_OFF constant, and the active-low polarity convention.
- Single sub-module: Seg7_lut, instantiated once on the muxed nibble; no per-digit decoders.
- Counter, index, frames and blanking logic stay in seg7_scan_ctrl.

Test Plan (bench uses NUM_DIG=4, SCAN_DIV=8, BLANK_CYC=2):
- Reset: hold iRST 3 cycles during active scan -> next cycle oSEL=4'hF, oSEG=8'hFF, oPEND=0; scan restarts at digit 0, cnt 0.
- Scan sequence: write data 16'h1234, dp=0 -> after the first commit, oFRAME pulses. In each 8-cycle slot: 2 cycles of oSEL=F/oSEG=FF, then 6 cycles of select low. Digit order and patterns: digit0 oSEL=E/oSEG=8'h99 (4); digit1 D/8'hB0 (3); digit2 B/8'hA4 (2); digit3 7/8'hF9 (1). Then wrap.
- Double buffer: write 16'hAAAA mid-frame, then 16'h00F0 before the boundary -> oPEND=1 until the boundary; the current frame still shows the old data; the next frame shows F0, never AAAA.
- Boundary bypass: iWR_EN exactly on the commit-boundary cycle with 16'h5555 -> the next frame shows 5555; oPEND=0 after that cycle.
- Leading-zero blank: iLZB=1, data 16'h0050, dp=4'b0000 -> digits 3 and 2 show 7'h7F, digit1 oSEG=8'h92, digit0 8'hC0. Repeat with dp=4'b1000 -> digit3 shows oSEG=8'h40 (no blanking below it).
- Live iLZB toggle mid-frame: with data 16'h0007, switch iLZB 0->1 -> blanking changes from the next slot's active window without waiting for a commit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: default timing and pin polarity.
package seg7_pkg;
  localparam int DEF_SCAN_DIV  = 50000;
  localparam int DEF_BLANK_CYC = 16;
  localparam int MAX_DIG       = 8;

  // Board pins are active-low: a 0 lights a segment or enables a digit.
  localparam logic SEG_ON = 1'b0;
  localparam logic SEL_ON = 1'b0;

  localparam logic [7:0]         SEG_OFF   = 8'hFF;
  localparam logic [6:0]         SEG_BLANK = 7'h7F;
  localparam logic [MAX_DIG-1:0] SEL_OFF   = '1;
endpackage

// File: rtl/Seg7_lut.sv
// Hex nibble to active-low {g..a} segment pattern.
module Seg7_lut (
  input  logic [3:0] iDIG,
  output logic [6:0] oSEG
);
  // Pure lookup, one decoder shared by all digits.
  always_comb begin
    oSEG = 7'h7F;
    case (iDIG)
      4'h0: oSEG = 7'h40;
      4'h1: oSEG = 7'h79;
      4'h2: oSEG = 7'h24;
      4'h3: oSEG = 7'h30;
      4'h4: oSEG = 7'h19;
      4'h5: oSEG = 7'h12;
      4'h6: oSEG = 7'h02;
      4'h7: oSEG = 7'h78;
      4'h8: oSEG = 7'h00;
      4'h9: oSEG = 7'h10;
      4'hA: oSEG = 7'h08;
      4'hB: oSEG = 7'h03;
      4'hC: oSEG = 7'h46;
      4'hD: oSEG = 7'h21;
      4'hE: oSEG = 7'h06;
      4'hF: oSEG = 7'h0E;
      default: oSEG = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with a double-buffered frame,
// per-slot ghosting blank and optional leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iWR_EN,
  input  logic [4*NUM_DIG-1:0] iWR_DATA,
  input  logic [NUM_DIG-1:0]   iWR_DP,
  input  logic                 iLZB,
  output logic                 oPEND,
  output logic                 oFRAME,
  output logic [NUM_DIG-1:0]   oSEL,
  output logic [7:0]           oSEG
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIG - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NUM_DIG-1:0] shd_data_q, shd_data_d, dsp_data_q, dsp_data_d;
  logic [NUM_DIG-1:0]   shd_dp_q, shd_dp_d, dsp_dp_q, dsp_dp_d;
  logic                 pend_q, pend_d, frame_q, frame_d;
  logic [NUM_DIG-1:0]   sel_q, sel_d;
  logic [7:0]           seg_q, seg_d;

  logic                 slot_end, commit;
  logic [3:0]           cur_nib;
  logic                 cur_dp;
  logic [6:0]           lut_seg;
  logic [NUM_DIG-1:0]   blank_vec;
  logic                 run;

  assign slot_end = (cnt_q == CNT_LAST);
  assign commit   = slot_end && (idx_q == IDX_LAST);
  assign cur_nib  = dsp_data_q[{idx_q, 2'b00} +: 4];
  assign cur_dp   = dsp_dp_q[idx_q];

  Seg7_lut u_lut (.iDIG(cur_nib), .oSEG(lut_seg));

  // Slot counter and digit index; index steps on the last cycle of a slot.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // Shadow/display buffering; display only changes on the commit boundary,
  // and a write landing on that boundary goes straight through.
  always_comb begin
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    dsp_data_d = dsp_data_q;
    dsp_dp_d   = dsp_dp_q;
    pend_d     = pend_q;
    frame_d    = commit;
    if (commit) begin
      pend_d = 1'b0;
      if (iWR_EN) begin
        shd_data_d = iWR_DATA;
        shd_dp_d   = iWR_DP;
        dsp_data_d = iWR_DATA;
        dsp_dp_d   = iWR_DP;
      end else begin
        dsp_data_d = shd_data_q;
        dsp_dp_d   = shd_dp_q;
      end
    end else if (iWR_EN) begin
      shd_data_d = iWR_DATA;
      shd_dp_d   = iWR_DP;
      pend_d     = 1'b1;
    end
  end

  // Leading-zero mask: a digit blanks while it and everything above it is a
  // zero nibble with no decimal point. Digit 0 always shows.
  always_comb begin
    run       = 1'b1;
    blank_vec = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      run          = run & (dsp_data_q[4*k +: 4] == 4'h0) & ~dsp_dp_q[k];
      blank_vec[k] = run;
    end
  end

  // Next pin state: dark during the ghosting window, else drive digit idx.
  always_comb begin
    sel_d = SEL_OFF[NUM_DIG-1:0];
    seg_d = SEG_OFF;
    if (cnt_q >= CNT_BLANK) begin
      sel_d[idx_q] = SEL_ON;
      seg_d = {cur_dp ? SEG_ON : ~SEG_ON,
               (iLZB && blank_vec[idx_q]) ? SEG_BLANK : lut_seg};
    end
  end

  // State and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      dsp_data_q <= '0;
      dsp_dp_q   <= '0;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
      sel_q      <= SEL_OFF[NUM_DIG-1:0];
      seg_q      <= SEG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      dsp_data_q <= dsp_data_d;
      dsp_dp_q   <= dsp_dp_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign oPEND  = pend_q;
  assign oFRAME = frame_q;
  assign oSEL   = sel_q;
  assign oSEG   = seg_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIG=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;
  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iWR_EN = 1'b0;
  logic [15:0] iWR_DATA = '0;
  logic [3:0]  iWR_DP = '0;
  logic        iLZB = 1'b0;
  logic        oPEND, oFRAME;
  logic [3:0]  oSEL;
  logic [7:0]  oSEG;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_ctrl #(.NUM_DIG(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iWR_EN(iWR_EN), .iWR_DATA(iWR_DATA),
    .iWR_DP(iWR_DP), .iLZB(iLZB), .oPEND(oPEND), .oFRAME(oFRAME),
    .oSEL(oSEL), .oSEG(oSEG)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Runs one 32-cycle frame starting from the cycle oFRAME is high (t=0).
  // Output at t reflects cnt/idx of t-1: digit d is dark at t=8d+1..8d+2 and
  // lit at t=8d+3..8d+8. Up to two writes (t in 1..31) and one iLZB switch at
  // the start of digit sw_dig are applied along the way.
  task automatic run_frame(input string name,
                           input logic [3:0][7:0] exp_a,
                           input logic [3:0][7:0] exp_b,
                           input int sw_dig, input logic lzb_new,
                           input int w1_t, input logic [15:0] w1_d, input logic [3:0] w1_dp,
                           input int w2_t, input logic [15:0] w2_d, input logic [3:0] w2_dp,
                           input logic pend0);
    logic       exp_pend;
    logic [3:0] esel;
    logic [7:0] eseg;
    int d, ph;
    exp_pend = pend0;
    for (int t = 1; t <= 32; t++) begin
      @(negedge iCLK);
      iWR_EN = 1'b0;
      d  = (t - 1) / 8;
      ph = (t - 1) % 8;
      esel = 4'hF;
      eseg = 8'hFF;
      if (ph >= 2) begin
        esel[d] = 1'b0;
        eseg = (d >= sw_dig) ? exp_b[d] : exp_a[d];
      end
      n_tests++;
      if (oSEL !== esel) begin
        n_fail++;
        $display("FAIL %s sel t=%0d: got %h want %h", name, t, oSEL, esel);
      end
      n_tests++;
      if (oSEG !== eseg) begin
        n_fail++;
        $display("FAIL %s seg t=%0d: got %h want %h", name, t, oSEG, eseg);
      end
      n_tests++;
      if (oFRAME !== (t == 32)) begin
        n_fail++;
        $display("FAIL %s frame t=%0d: got %b want %b", name, t, oFRAME, (t == 32));
      end
      n_tests++;
      if (oPEND !== exp_pend) begin
        n_fail++;
        $display("FAIL %s pend t=%0d: got %b want %b", name, t, oPEND, exp_pend);
      end
      if (t == w1_t || t == w2_t) begin
        iWR_EN   = 1'b1;
        iWR_DATA = (t == w1_t) ? w1_d : w2_d;
        iWR_DP   = (t == w1_t) ? w1_dp : w2_dp;
        exp_pend = (t != 31);
      end else if (t == 31) begin
        exp_pend = 1'b0;
      end
      if (sw_dig < 4 && t == 8 * sw_dig + 1) iLZB = lzb_new;
    end
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge iCLK);
      n_tests++;
      if (oSEL !== 4'hF || oSEG !== 8'hFF || oPEND !== 1'b0 || oFRAME !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_init: got sel=%h seg=%h pend=%b frame=%b want F FF 0 0",
                 oSEL, oSEG, oPEND, oFRAME);
      end
    end
    iRST = 1'b0;
    repeat (12) @(negedge iCLK);
    iWR_EN = 1'b1; iWR_DATA = 16'h9999; iWR_DP = 4'h0;
    @(negedge iCLK);
    iWR_EN = 1'b0;
    n_tests++;
    if (oPEND !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prewrite_pend: got %b want 1", oPEND);
    end
    iRST = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      n_tests++;
      if (oSEL !== 4'hF || oSEG !== 8'hFF || oPEND !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid: got sel=%h seg=%h pend=%b want F FF 0", oSEL, oSEG, oPEND);
      end
    end
    iRST = 1'b0;
    repeat (2) begin
      @(negedge iCLK);
      n_tests++;
      if (oSEL !== 4'hF || oSEG !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_restart_blank: got sel=%h seg=%h want F FF", oSEL, oSEG);
      end
    end
    @(negedge iCLK);
    n_tests++;
    if (oSEL !== 4'hE || oSEG !== 8'hC0 || oPEND !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart_dig0: got sel=%h seg=%h pend=%b want E C0 0",
               oSEL, oSEG, oPEND);
    end
  endtask

  task automatic sync_frame(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge iCLK);
      if (oFRAME === 1'b1) break;
    end
    n_tests++;
    if (oFRAME !== 1'b1) begin
      n_fail++;
      $display("FAIL %s sync: got frame=%b want 1 within 80 cycles", name, oFRAME);
    end
    n_tests++;
    if (oPEND !== 1'b0) begin
      n_fail++;
      $display("FAIL %s sync_pend: got %b want 0", name, oPEND);
    end
  endtask

  task automatic test_scan;
    iWR_EN = 1'b1; iWR_DATA = 16'h1234; iWR_DP = 4'h0;
    @(negedge iCLK);
    iWR_EN = 1'b0;
    n_tests++;
    if (oPEND !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_write_pend: got %b want 1", oPEND);
    end
    sync_frame("scan");
    run_frame("scan_f1", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99},
              4, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
    run_frame("scan_f2", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99},
              4, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_double_buffer;
    run_frame("dbuf_old", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99},
              4, 1'b0, 5, 16'hAAAA, 4'h0, 20, 16'h00F0, 4'h0, 1'b0);
    run_frame("dbuf_new", {8'hC0, 8'hC0, 8'h8E, 8'hC0}, {8'hC0, 8'hC0, 8'h8E, 8'hC0},
              4, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_boundary_bypass;
    run_frame("bypass_wr", {8'hC0, 8'hC0, 8'h8E, 8'hC0}, {8'hC0, 8'hC0, 8'h8E, 8'hC0},
              4, 1'b0, 31, 16'h5555, 4'h0, 0, 16'h0, 4'h0, 1'b0);
    run_frame("bypass_new", {8'h92, 8'h92, 8'h92, 8'h92}, {8'h92, 8'h92, 8'h92, 8'h92},
              4, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_lzb;
    iLZB = 1'b1;
    run_frame("lzb_load", {8'h92, 8'h92, 8'h92, 8'h92}, {8'h92, 8'h92, 8'h92, 8'h92},
              4, 1'b0, 5, 16'h0050, 4'b0000, 0, 16'h0, 4'h0, 1'b0);
    run_frame("lzb_blank", {8'hFF, 8'hFF, 8'h92, 8'hC0}, {8'hFF, 8'hFF, 8'h92, 8'hC0},
              4, 1'b0, 5, 16'h0050, 4'b1000, 0, 16'h0, 4'h0, 1'b0);
    run_frame("lzb_dp3", {8'h40, 8'hC0, 8'h92, 8'hC0}, {8'h40, 8'hC0, 8'h92, 8'hC0},
              4, 1'b0, 5, 16'h0007, 4'b0000, 0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_lzb_toggle;
    iLZB = 1'b0;
    run_frame("lzb_toggle", {8'hC0, 8'hC0, 8'hC0, 8'hF8}, {8'hFF, 8'hFF, 8'hFF, 8'hF8},
              1, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
    run_frame("lzb_on", {8'hFF, 8'hFF, 8'hFF, 8'hF8}, {8'hFF, 8'hFF, 8'hFF, 8'hF8},
              4, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_buffer();
    test_boundary_bypass();
    test_lzb();
    test_lzb_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
